mod_reduce: RTL and testbench



---
 rtl/rsa_pkg.sv | 18 +
 rtl/mod_sub_step.sv | 33 +++
 rtl/mod_reduce.sv | 148 ++++++++++++++
 tb/tb_mod_reduce.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath slice.
// Purpose : operand widths shared by the 6x6 multiplier and the modular
//           reducer, plus the reducer's state encoding.
// Contents: PROD_W - width of the multiplier product
//           MOD_W  - width of the modulus / remainder
//           mr_state_t - reducer control states (IDLE, BUSY, DONE)
package rsa_pkg;

  localparam int PROD_W = 12;
  localparam int MOD_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mr_state_t;

endpackage

// File: rtl/mod_sub_step.sv
// One restoring shift-subtract step of a binary long division.
// Purpose : shifts the next dividend bit into the partial remainder and
//           subtracts the modulus when the shifted value is large enough.
//           Purely combinational so it can be replicated for an unrolled
//           or pipelined reducer.
// Ports   : r      in  MOD_W    partial remainder, always < n
//           bit_in in  1        next dividend bit (MSB first)
//           n      in  MOD_W    modulus
//           r_next out MOD_W    updated partial remainder, < n
module mod_sub_step #(
  parameter int MOD_W = 6
) (
  input  logic [MOD_W-1:0] r,
  input  logic             bit_in,
  input  logic [MOD_W-1:0] n,
  output logic [MOD_W-1:0] r_next
);

  logic [MOD_W:0] t;
  logic [MOD_W:0] n_ext;

  // The shifted value needs one extra bit; since r < n the result after a
  // conditional subtract fits back in MOD_W bits.
  always_comb begin
    t      = {r, bit_in};
    n_ext  = {1'b0, n};
    r_next = t[MOD_W-1:0];
    if (t >= n_ext) begin
      r_next = MOD_W'(t - n_ext);
    end
  end

endmodule

// File: rtl/mod_reduce.sv
// Sequential modular reducer: remainder = product mod modulus.
// Purpose : sits behind the 6x6 multiplier in the RSA datapath and reduces
//           the 12-bit product one bit per clock with restoring
//           shift-subtract. Valid/ready handshakes on both sides.
// Ports   : clk       in  1       rising-edge clock
//           rst       in  1       synchronous active-high reset
//           in_valid  in  1       product/modulus presented
//           in_ready  out 1       block can accept an operand pair
//           product   in  PROD_W  value to reduce
//           modulus   in  MOD_W   modulus n
//           out_valid out 1       result available
//           out_ready in  1       consumer accepts result
//           remainder out MOD_W   product mod n (0 when not valid)
//           err_div0  out 1       modulus was zero, qualified by out_valid
// Config  : MOD_REDUCE_FASTPATH_EN - when defined, a product already smaller
//           than a nonzero modulus skips the BUSY phase and is reported the
//           cycle after acceptance. Results are identical either way.
module mod_reduce #(
  parameter int PROD_W = rsa_pkg::PROD_W,
  parameter int MOD_W  = rsa_pkg::MOD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic [MOD_W-1:0]  modulus,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MOD_W-1:0]  remainder,
  output logic              err_div0
);

  localparam int CNT_W = $clog2(PROD_W);

  rsa_pkg::mr_state_t state;
  rsa_pkg::mr_state_t next_state;

  logic [PROD_W-1:0] prod_q;
  logic [MOD_W-1:0]  mod_q;
  logic [MOD_W-1:0]  r_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic [MOD_W-1:0]  r_step;
  logic              div0;
  logic              fast;

  mod_sub_step #(
    .MOD_W(MOD_W)
  ) u_step (
    .r     (r_q),
    .bit_in(prod_q[cnt_q]),
    .n     (mod_q),
    .r_next(r_step)
  );

  // Accept-time decisions, taken from the live inputs in the IDLE cycle.
  always_comb begin
    div0 = (modulus == '0);
`ifdef MOD_REDUCE_FASTPATH_EN
    fast = !div0 && (product < {{(PROD_W-MOD_W){1'b0}}, modulus});
`else
    fast = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= rsa_pkg::IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. DONE always returns through IDLE, so a new operand is
  // never taken on the same edge a result is consumed.
  always_comb begin
    next_state = state;
    case (state)
      rsa_pkg::IDLE: begin
        if (in_valid) begin
          if (div0 || fast) begin
            next_state = rsa_pkg::DONE;
          end else begin
            next_state = rsa_pkg::BUSY;
          end
        end
      end
      rsa_pkg::BUSY: begin
        if (cnt_q == '0) begin
          next_state = rsa_pkg::DONE;
        end
      end
      rsa_pkg::DONE: begin
        if (out_ready) begin
          next_state = rsa_pkg::IDLE;
        end
      end
      default: next_state = rsa_pkg::IDLE;
    endcase
  end

  // Outputs. The remainder is forced to zero outside DONE so partial
  // values from the BUSY phase never leak onto the bus.
  always_comb begin
    in_ready  = (state == rsa_pkg::IDLE);
    out_valid = (state == rsa_pkg::DONE);
    remainder = '0;
    err_div0  = 1'b0;
    if (state == rsa_pkg::DONE) begin
      remainder = r_q;
      err_div0  = err_q;
    end
  end

  // Datapath: capture operands on accept, then walk the product MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      mod_q  <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        rsa_pkg::IDLE: begin
          if (in_valid) begin
            prod_q <= product;
            mod_q  <= modulus;
            cnt_q  <= CNT_W'(PROD_W - 1);
            err_q  <= div0;
            r_q    <= fast ? product[MOD_W-1:0] : '0;
          end
        end
        rsa_pkg::BUSY: begin
          r_q <= r_step;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reduce.sv
// Directed testbench for mod_reduce. Expected remainders are hand-computed;
// expected latency follows from the fast-path build option.
module tb_mod_reduce;

`ifdef MOD_REDUCE_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] product;
  logic [5:0]  modulus;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  remainder;
  logic        err_div0;

  int checks   = 0;
  int failures = 0;

  mod_reduce dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .product  (product),
    .modulus  (modulus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .remainder(remainder),
    .err_div0 (err_div0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int expLat(input int p, input int m);
    if (m == 0) return 1;
    if (FAST && p < m) return 1;
    return 13;
  endfunction

  // Present an operand pair until accepted; returns #1 after the accept edge
  // with the inputs scrambled, since they need not stay stable.
  task automatic applyStimulus(input logic [11:0] p, input logic [5:0] m);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    product  = p;
    modulus  = m;
    for (int i = 0; i < 50; i++) begin
      accepted = in_ready;
      @(posedge clk);
      #1;
      if (accepted) break;
    end
    in_valid = 1'b0;
    product  = 12'hABC;
    modulus  = 6'h2A;
    checkOutput("accept", int'(accepted), 1);
  endtask

  // Counts cycles from the accept edge (as 1) until out_valid is seen.
  task automatic waitResult(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input int p, input int m, input int expRem);
    int lat;
    out_ready = 1'b1;
    applyStimulus(12'(p), 6'(m));
    waitResult(lat);
    checkOutput({tag, "_lat"}, lat, expLat(p, m));
    checkOutput({tag, "_rem"}, int'(remainder), expRem);
    checkOutput({tag, "_err"}, int'(err_div0), (m == 0) ? 1 : 0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_consumed"}, int'(out_valid), 0);
  endtask

  initial begin
    int  lat;
    bit  stable;
    rst       = 1'b1;
    in_valid  = 1'b0;
    product   = '0;
    modulus   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_rem", int'(remainder), 0);
    checkOutput("rst_err", int'(err_div0), 0);
    rst = 1'b0;

    // Single operation and large operands.
    runOp("op3591_61", 3591, 61, 53);
    runOp("op3969_63", 3969, 63, 0);
    runOp("op143_7", 143, 7, 3);
    runOp("op4095_62", 4095, 62, 3);
    runOp("op4095_32", 4095, 32, 31);
    runOp("n_one", 2345, 1, 0);
    runOp("prod_zero", 0, 13, 0);
    runOp("prod_lt_mod", 40, 45, 40);

    // Divide by zero, held by backpressure for two cycles.
    out_ready = 1'b0;
    applyStimulus(12'd100, 6'd0);
    waitResult(lat);
    checkOutput("div0_lat", lat, 1);
    checkOutput("div0_err", int'(err_div0), 1);
    checkOutput("div0_rem", int'(remainder), 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("div0_hold_in_ready", int'(in_ready), 0);
    checkOutput("div0_hold_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("div0_release_valid", int'(out_valid), 0);
    checkOutput("div0_release_in_ready", int'(in_ready), 1);

    // Backpressure with stray in_valid pulses during BUSY and DONE.
    out_ready = 1'b0;
    applyStimulus(12'd1000, 6'd37);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      product  = 12'd77;
      modulus  = 6'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    waitResult(lat);
    checkOutput("bp_lat", 10 + lat, 13);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 3 == 0);
      product  = 12'd5;
      modulus  = 6'd7;
      @(posedge clk);
      #1;
      if (!(out_valid === 1'b1 && remainder === 6'd1 && err_div0 === 1'b0)) stable = 1'b0;
    end
    in_valid = 1'b0;
    checkOutput("bp_stable", int'(stable), 1);
    checkOutput("bp_in_ready_low", int'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", int'(out_valid), 0);
    checkOutput("bp_release_in_ready", int'(in_ready), 1);

    // Reset in the middle of BUSY discards the operation.
    applyStimulus(12'd3591, 6'd61);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_in_ready", int'(in_ready), 1);
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    repeat (14) @(posedge clk);
    #1;
    checkOutput("midrst_no_output", int'(out_valid), 0);
    runOp("op500_9", 500, 9, 5);

    // Fast-path candidate: same result in both builds, latency differs.
    runOp("fast5_7", 5, 7, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
